neural_soc_sw_sig_ctrl: RTL and testbench



---
 rtl/neural_soc_sw_sig_ctrl_pkg.sv | 40 ++++
 rtl/neural_soc_sw_cmd_edge.sv | 31 +++
 rtl/neural_soc_sw_sig_ctrl.sv | 111 +++++++++++
 tb/tb_neural_soc_sw_sig_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_soc_sw_sig_ctrl_pkg.sv
// Shared codes for the software/engine handshake sequencer:
// PIO command codes, status codes, error causes and FSM encodings.
package neural_soc_sw_sig_ctrl_pkg;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_START = 2'b01;
   localparam logic [1:0] CMD_ACK   = 2'b10;
   localparam logic [1:0] CMD_ABORT = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;
   localparam logic [1:0] ST_ERROR = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ENGINE  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_ABORT   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   function automatic logic [1:0] status_of(state_t s);
      logic [1:0] r;
      r = ST_IDLE;
      unique case (s)
         S_START, S_RUN: r = ST_BUSY;
         S_DONE:         r = ST_DONE;
         S_ERROR:        r = ST_ERROR;
         default:        r = ST_IDLE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/neural_soc_sw_cmd_edge.sv
// Turns the software command level into one-cycle command pulses;
// a code counts only when it differs from last cycle and is non-zero.
module neural_soc_sw_cmd_edge
   import neural_soc_sw_sig_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] from_sw_sig,
   output logic       cmd_start,
   output logic       cmd_ack,
   output logic       cmd_abort
);

   logic [1:0] sw_prev;
   logic       valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_prev <= CMD_NONE;
      end else begin
         sw_prev <= from_sw_sig;
      end
   end

   assign valid = (from_sw_sig != sw_prev) && (from_sw_sig != CMD_NONE);

   assign cmd_start = valid && (from_sw_sig == CMD_START);
   assign cmd_ack   = valid && (from_sw_sig == CMD_ACK);
   assign cmd_abort = valid && (from_sw_sig == CMD_ABORT);

endmodule

// File: rtl/neural_soc_sw_sig_ctrl.sv
// Hardware/software handshake sequencer: starts the neural engine,
// watches it with a timeout and holds DONE/ERROR until software ACKs.
module neural_soc_sw_sig_ctrl
   import neural_soc_sw_sig_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       from_sw_sig,
   input  logic             nn_done,
   input  logic             nn_error,
   output logic             nn_start,
   output logic             nn_abort,
   output logic [1:0]       to_sw_sig,
   output logic [1:0]       err_cause,
   output logic [CNT_W-1:0] run_count
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic             cmd_start;
   logic             cmd_ack;
   logic             cmd_abort;
   state_t           state;
   state_t           state_nx;
   logic [TW-1:0]    tmo;
   logic [TW-1:0]    tmo_nx;
   logic [1:0]       cause_nx;
   logic             abort_nx;
   logic [CNT_W-1:0] cnt_nx;

   neural_soc_sw_cmd_edge u_cmd_edge (
      .clk         (clk),
      .reset_n     (reset_n),
      .from_sw_sig (from_sw_sig),
      .cmd_start   (cmd_start),
      .cmd_ack     (cmd_ack),
      .cmd_abort   (cmd_abort)
   );

   always_comb begin
      state_nx = state;
      tmo_nx   = tmo;
      cause_nx = err_cause;
      abort_nx = 1'b0;
      cnt_nx   = run_count;
      unique case (state)
         S_IDLE: begin
            if (cmd_start) state_nx = S_START;
         end
         S_START: begin
            state_nx = S_RUN;
            tmo_nx   = '0;
         end
         S_RUN: begin
            tmo_nx = tmo + 1'b1;
            // Exit order: software abort, engine fault, completion, timeout.
            if (cmd_abort) begin
               state_nx = S_ERROR;
               cause_nx = ERR_ABORT;
               abort_nx = 1'b1;
            end else if (nn_error) begin
               state_nx = S_ERROR;
               cause_nx = ERR_ENGINE;
            end else if (nn_done) begin
               state_nx = S_DONE;
               cnt_nx   = run_count + 1'b1;
            end else if (tmo == T_LAST) begin
               state_nx = S_ERROR;
               cause_nx = ERR_TIMEOUT;
               abort_nx = 1'b1;
            end
         end
         S_DONE: begin
            if (cmd_ack) state_nx = S_IDLE;
         end
         S_ERROR: begin
            if (cmd_ack) begin
               state_nx = S_IDLE;
               cause_nx = ERR_NONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they move with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         tmo       <= '0;
         err_cause <= ERR_NONE;
         nn_abort  <= 1'b0;
         nn_start  <= 1'b0;
         to_sw_sig <= ST_IDLE;
         run_count <= '0;
      end else begin
         state     <= state_nx;
         tmo       <= tmo_nx;
         err_cause <= cause_nx;
         nn_abort  <= abort_nx;
         nn_start  <= (state_nx == S_START);
         to_sw_sig <= status_of(state_nx);
         run_count <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_neural_soc_sw_sig_ctrl.sv
// Scoreboard bench: stimulus pushes expected output-change events,
// a negedge monitor pops one whenever any DUT output changes.
module tb_neural_soc_sw_sig_ctrl;

   localparam int TMO = 16;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [1:0]    from_sw_sig = 2'b00;
   logic          nn_done = 1'b0;
   logic          nn_error = 1'b0;
   logic          nn_start;
   logic          nn_abort;
   logic [1:0]    to_sw_sig;
   logic [1:0]    err_cause;
   logic [CW-1:0] run_count;

   neural_soc_sw_sig_ctrl #(
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .from_sw_sig (from_sw_sig),
      .nn_done     (nn_done),
      .nn_error    (nn_error),
      .nn_start    (nn_start),
      .nn_abort    (nn_abort),
      .to_sw_sig   (to_sw_sig),
      .err_cause   (err_cause),
      .run_count   (run_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [1:0]    st;
      logic [1:0]    cause;
      logic [CW-1:0] cnt;
      logic          start;
      logic          abort;
   } ev_t;

   ev_t exp_q[$];
   ev_t prev = '{0, 2'b00, 2'b00, '0, 1'b0, 1'b0};
   ev_t cur;
   ev_t e;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int mcount = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      cur = '{cyc, to_sw_sig, err_cause, run_count, nn_start, nn_abort};
      if (cur.st != prev.st || cur.cause != prev.cause ||
          cur.cnt != prev.cnt || cur.start != prev.start ||
          cur.abort != prev.abort) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d st=%b cause=%b cnt=%0d start=%b abort=%b",
                     cur.cyc, cur.st, cur.cause, cur.cnt, cur.start, cur.abort);
         end else begin
            e = exp_q.pop_front();
            if (cur.cyc != e.cyc || cur.st != e.st || cur.cause != e.cause ||
                cur.cnt != e.cnt || cur.start != e.start || cur.abort != e.abort) begin
               errors++;
               $display("FAIL event got cyc=%0d st=%b cause=%b cnt=%0d start=%b abort=%b want cyc=%0d st=%b cause=%b cnt=%0d start=%b abort=%b",
                        cur.cyc, cur.st, cur.cause, cur.cnt, cur.start, cur.abort,
                        e.cyc, e.st, e.cause, e.cnt, e.start, e.abort);
            end
         end
      end
      prev = cur;
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(int c, logic [1:0] st, logic [1:0] cause,
                       logic s, logic a);
      exp_q.push_back('{c, st, cause, CW'(mcount), s, a});
   endtask

   task automatic check_reset_vals(string name);
      checks++;
      if (to_sw_sig !== 2'b00 || err_cause !== 2'b00 || run_count !== '0 ||
          nn_start !== 1'b0 || nn_abort !== 1'b0) begin
         errors++;
         $display("FAIL %s got st=%b cause=%b cnt=%0d start=%b abort=%b want all zero",
                  name, to_sw_sig, err_cause, run_count, nn_start, nn_abort);
      end
   endtask

   // Issue START; returns the edge at which RUN is entered.
   task automatic do_start(bit rel, output int r);
      int s;
      s = cyc;
      from_sw_sig = 2'b01;
      push(s + 1, 2'b01, 2'b00, 1'b1, 1'b0);
      push(s + 2, 2'b01, 2'b00, 1'b0, 1'b0);
      tick(2);
      r = s + 2;
      if (rel) from_sw_sig = 2'b00;
   endtask

   task automatic finish_done(int dly);
      int d;
      tick(dly);
      d = cyc;
      mcount = (mcount + 1) % (1 << CW);
      push(d + 1, 2'b10, 2'b00, 1'b0, 1'b0);
      nn_done = 1'b1;
      tick(1);
      nn_done = 1'b0;
   endtask

   task automatic finish_error(int dly);
      int d;
      tick(dly);
      d = cyc;
      push(d + 1, 2'b11, 2'b01, 1'b0, 1'b0);
      nn_error = 1'b1;
      tick(1);
      nn_error = 1'b0;
   endtask

   task automatic finish_abort(int dly);
      int d;
      tick(dly);
      d = cyc;
      from_sw_sig = 2'b11;
      push(d + 1, 2'b11, 2'b11, 1'b0, 1'b1);
      push(d + 2, 2'b11, 2'b11, 1'b0, 1'b0);
      tick(2);
   endtask

   task automatic finish_timeout(int r);
      push(r + TMO, 2'b11, 2'b10, 1'b0, 1'b1);
      push(r + TMO + 1, 2'b11, 2'b10, 1'b0, 1'b0);
      tick(r + TMO + 1 - cyc);
   endtask

   task automatic do_ack();
      int a;
      from_sw_sig = 2'b00;
      tick(1);
      a = cyc;
      from_sw_sig = 2'b10;
      push(a + 1, 2'b00, 2'b00, 1'b0, 1'b0);
      tick(2);
      from_sw_sig = 2'b00;
      tick(1);
   endtask

   initial begin
      int r;
      int a;
      int c;
      int kind;
      #1 reset_n = 1'b0;
      #2 check_reset_vals("reset_state");
      tick(2);
      reset_n = 1'b1;
      tick(2);

      // Normal run: done sampled 6 edges after the nn_start edge.
      do_start(1'b1, r);
      finish_done(4);
      do_ack();

      // Timeout with no completion.
      do_start(1'b1, r);
      finish_timeout(r);
      do_ack();

      // ABORT, nn_error and nn_done in the same cycle.
      do_start(1'b1, r);
      tick(3);
      c = cyc;
      from_sw_sig = 2'b11;
      nn_error = 1'b1;
      nn_done = 1'b1;
      push(c + 1, 2'b11, 2'b11, 1'b0, 1'b1);
      push(c + 2, 2'b11, 2'b11, 1'b0, 1'b0);
      tick(1);
      nn_error = 1'b0;
      nn_done = 1'b0;
      tick(1);
      do_ack();

      // Level held at START through DONE: no restart, stray events dropped.
      do_start(1'b0, r);
      finish_done(2);
      tick(5);
      a = cyc;
      from_sw_sig = 2'b10;
      push(a + 1, 2'b00, 2'b00, 1'b0, 1'b0);
      tick(3);
      nn_done = 1'b1;
      tick(1);
      nn_done = 1'b0;
      nn_error = 1'b1;
      tick(1);
      nn_error = 1'b0;
      tick(2);
      from_sw_sig = 2'b00;
      tick(1);
      do_start(1'b1, r);
      finish_done(1);
      do_ack();

      for (int i = 0; i < 12; i++) begin
         kind = int'($urandom_range(0, 3));
         do_start(1'($urandom_range(0, 1)), r);
         unique case (kind)
            0: finish_done(int'($urandom_range(0, 13)));
            1: finish_error(int'($urandom_range(0, 13)));
            2: finish_abort(int'($urandom_range(0, 13)));
            default: finish_timeout(r);
         endcase
         do_ack();
      end

      // Asynchronous reset in the middle of RUN.
      do_start(1'b1, r);
      tick(3);
      c = cyc;
      from_sw_sig = 2'b00;
      reset_n = 1'b0;
      mcount = 0;
      push(c, 2'b00, 2'b00, 1'b0, 1'b0);
      #1 check_reset_vals("async_reset");
      tick(1);
      reset_n = 1'b1;
      tick(2);

      // Four good runs wrap the 2-bit counter back to zero.
      for (int i = 0; i < 4; i++) begin
         do_start(1'b1, r);
         finish_done(int'($urandom_range(0, 13)));
         do_ack();
      end
      checks++;
      if (run_count !== CW'(mcount)) begin
         errors++;
         $display("FAIL wrap_count got %0d want %0d", run_count, mcount);
      end

      tick(5);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
